// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: active-high gfedcba segment
// patterns, active-low anode patterns and the slot FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_D0  = 4'b1110;
  localparam logic [3:0] ANODE_D1  = 4'b1101;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b0111;

  typedef enum logic {
    PH_GAP   = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  // Slot index 0 is the rightmost digit.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    case (idx)
      2'd0:    anode_for = ANODE_D0;
      2'd1:    anode_for = ANODE_D1;
      2'd2:    anode_for = ANODE_D2;
      default: anode_for = ANODE_D3;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high gfedcba segment decode; non-decimal codes are blank.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver: slot scanning, frame-latched
// inputs, one-cycle ghost blanking on every slot change, edit-digit blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] num,
  input  logic [3:0]  blink_sel,
  input  logic [3:0]  dp_mask,
  input  logic        blank,
  output logic [3:0]  anode,
  output logic [7:0]  eSeg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [PW-1:0] r_presc;
  logic          r_tick_d;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [15:0]   r_num_sh;
  logic [3:0]    r_blink_sh;
  logic [3:0]    r_dp_sh;
  phase_t        r_phase;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic          w_lit;
  phase_t        w_phase_nxt;
  logic [3:0]    w_anode_nxt;
  logic [7:0]    w_eseg_nxt;

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_frame_end = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_tick_d <= 1'b0;
      r_idx    <= 2'd0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      r_tick_d <= w_tick;
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BW'(1);
      end
    end
  end

  // Inputs are sampled only at the end of the idx3 slot so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_sh   <= '0;
      r_blink_sh <= '0;
      r_dp_sh    <= '0;
    end else if (w_frame_end) begin
      r_num_sh   <= num;
      r_blink_sh <= blink_sel;
      r_dp_sh    <= dp_mask;
    end
  end

  always_comb begin
    w_digit = r_num_sh[3:0];
    case (r_idx)
      2'd0:    w_digit = r_num_sh[3:0];
      2'd1:    w_digit = r_num_sh[7:4];
      2'd2:    w_digit = r_num_sh[11:8];
      default: w_digit = r_num_sh[15:12];
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  assign w_lit = ~blank & ~(r_blink_phase & r_blink_sh[r_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_phase <= PH_GAP;
    else       r_phase <= w_phase_nxt;
  end

  // GAP only leaves on the cycle after a tick; after reset it therefore
  // stays dark until the first slot boundary.
  always_comb begin
    w_phase_nxt = r_phase;
    w_anode_nxt = ANODE_OFF;
    w_eseg_nxt  = 8'hFF;
    if (r_phase == PH_GAP) begin
      if (r_tick_d) w_phase_nxt = PH_DRIVE;
    end
    if (w_tick) w_phase_nxt = PH_GAP;
    if ((w_phase_nxt == PH_DRIVE) && w_lit) begin
      w_anode_nxt = anode_for(r_idx);
      w_eseg_nxt  = {~r_dp_sh[r_idx], ~w_seg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode <= ANODE_OFF;
      eSeg  <= 8'hFF;
    end else begin
      anode <= w_anode_nxt;
      eSeg  <= w_eseg_nxt;
    end
  end

endmodule
